// File: rtl/seq_det_sched.sv
// Armable serial pattern detector: loads a PAT_W-bit pattern, shifts qualified bits
// through a history register and holds each match as an event until acknowledged.
module seq_det_sched #(
    parameter int PAT_W = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             arm,
    input  logic             disarm,
    input  logic             x,
    input  logic             x_valid,
    output logic             x_ready,
    output logic             match_valid,
    input  logic             match_ready,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat,
    output logic [1:0]       state
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t cur, nxt;

    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic             loaded;
    logic [PAT_W-1:0] hist;
    logic [FW-1:0]    fill;
    logic [CNT_W-1:0] count;
    logic             sat;

    logic [PAT_W-1:0] hist_nxt;
    logic [FW-1:0]    fill_inc;
    logic             hit;
    logic             do_cfg, do_arm, do_shift, do_match;

    // fill only reaches FULL once PAT_W fresh bits have arrived since arm/last match
    assign hist_nxt = {hist[PAT_W-2:0], x};
    assign fill_inc = (fill == FULL) ? FULL : fill + FW'(1);
    assign hit      = (fill_inc == FULL) && (hist_nxt == pattern);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= IDLE;
        else      cur <= nxt;
    end

    always_comb begin
        nxt      = cur;
        do_cfg   = 1'b0;
        do_arm   = 1'b0;
        do_shift = 1'b0;
        do_match = 1'b0;
        case (cur)
            IDLE: begin
                do_cfg = cfg_valid;
                if (arm && (loaded || cfg_valid)) begin
                    do_arm = 1'b1;
                    nxt    = ARMED;
                end
            end
            ARMED: begin
                if (disarm) begin
                    nxt = IDLE;
                end else if (x_valid) begin
                    do_shift = 1'b1;
                    if (hit) begin
                        do_match = 1'b1;
                        nxt      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (disarm)           nxt = IDLE;
                else if (match_ready) nxt = ARMED;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern <= '0;
            overlap <= 1'b0;
            loaded  <= 1'b0;
        end else if (do_cfg) begin
            pattern <= cfg_pattern;
            overlap <= cfg_overlap;
            loaded  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else if (do_arm) begin
            hist <= '0;
            fill <= '0;
        end else if (do_shift) begin
            hist <= hist_nxt;
            // non-overlapping mode must collect a whole new pattern after a hit
            fill <= (do_match && !overlap) ? '0 : fill_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (do_cfg) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (do_match) begin
            if (&count) sat <= 1'b1;
            else        count <= count + CNT_W'(1);
        end
    end

    assign cfg_ready   = (cur == IDLE);
    assign x_ready     = (cur == ARMED);
    assign match_valid = (cur == HOLD);
    assign match_count = count;
    assign count_sat   = sat;
    assign state       = cur;

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed per-cycle vector table for seq_det_sched with a 2-bit counter,
// plus a hand-written async reset during HOLD.
module tb_seq_det_sched;
    localparam int PAT_W = 6;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic             cfg_overlap = 1'b0;
    logic             arm = 1'b0;
    logic             disarm = 1'b0;
    logic             x = 1'b0;
    logic             x_valid = 1'b0;
    logic             x_ready;
    logic             match_valid;
    logic             match_ready = 1'b0;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    seq_det_sched #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
        .arm(arm), .disarm(disarm),
        .x(x), .x_valid(x_valid), .x_ready(x_ready),
        .match_valid(match_valid), .match_ready(match_ready),
        .match_count(match_count), .count_sat(count_sat),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             cv;
        logic [PAT_W-1:0] pat;
        logic             ov;
        logic             arm;
        logic             dis;
        logic             x;
        logic             xv;
        logic             mr;
        logic [1:0]       st;
        logic [CNT_W-1:0] cnt;
        logic             sat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic cv, input logic [PAT_W-1:0] pat, input logic ov,
                       input logic a, input logic d, input logic xb, input logic xv,
                       input logic mr, input logic [1:0] st, input logic [CNT_W-1:0] cnt,
                       input logic s);
        vec_t v;
        v.cv = cv; v.pat = pat; v.ov = ov; v.arm = a; v.dis = d;
        v.x = xb; v.xv = xv; v.mr = mr; v.st = st; v.cnt = cnt; v.sat = s;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic chk_all(input int row, input logic [1:0] st, input logic [CNT_W-1:0] cnt,
                           input logic s);
        chk("state", row, 8'(state), 8'(st));
        chk("cfg_ready", row, 8'(cfg_ready), 8'(st == 2'd0));
        chk("x_ready", row, 8'(x_ready), 8'(st == 2'd1));
        chk("match_valid", row, 8'(match_valid), 8'(st == 2'd2));
        chk("match_count", row, 8'(match_count), 8'(cnt));
        chk("count_sat", row, 8'(count_sat), 8'(s));
    endtask

    localparam logic [PAT_W-1:0] P0 = 6'b110110;
    localparam logic [PAT_W-1:0] P1 = 6'b101010;

    initial begin
        //   cv pat   ov arm dis x  xv mr   st cnt sat
        add(0, '0,   0, 1, 0, 0, 0, 0,   0, 0, 0); // 0 arm unloaded ignored
        add(1, P0,   0, 0, 0, 0, 0, 0,   0, 0, 0); // 1 load, no overlap
        add(0, '0,   0, 1, 0, 0, 0, 0,   1, 0, 0); // 2 arm
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 0, 0); // 3..8 stream 110110
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 0, 0);
        add(0, '0,   0, 0, 0, 0, 1, 1,   1, 0, 0);
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 0, 0);
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 0, 0);
        add(0, '0,   0, 0, 0, 0, 1, 1,   2, 1, 0); // 8 match one cycle later
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 1, 0); // 9 ack; offered bit dropped
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 1, 0); // 10..12 "110": refill only 3
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 1, 0);
        add(0, '0,   0, 0, 0, 0, 1, 1,   1, 1, 0);
        add(0, '0,   0, 0, 1, 1, 1, 1,   0, 1, 0); // 13 disarm with bit
        add(1, P0,   1, 1, 0, 0, 0, 0,   1, 0, 0); // 14 cfg+arm same cycle, overlap
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 0, 0); // 15..20 stream 110110
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 0, 0);
        add(0, '0,   0, 0, 0, 0, 1, 1,   1, 0, 0);
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 0, 0);
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 0, 0);
        add(0, '0,   0, 0, 0, 0, 1, 1,   2, 1, 0);
        add(0, '0,   0, 0, 0, 0, 0, 1,   1, 1, 0); // 21 ack
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 1, 0); // 22..24 "110" overlaps
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 1, 0);
        add(0, '0,   0, 0, 0, 0, 1, 1,   2, 2, 0);
        add(0, '0,   0, 0, 0, 1, 1, 0,   2, 2, 0); // 25..29 backpressure
        add(0, '0,   0, 0, 0, 1, 1, 0,   2, 2, 0);
        add(0, '0,   0, 0, 0, 1, 1, 0,   2, 2, 0);
        add(0, '0,   0, 0, 0, 1, 1, 0,   2, 2, 0);
        add(0, '0,   0, 0, 0, 1, 1, 0,   2, 2, 0);
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 2, 0); // 30 ack, bit not consumed
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 2, 0); // 31..33 "110" -> match
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 2, 0);
        add(0, '0,   0, 0, 0, 0, 1, 1,   2, 3, 0);
        add(0, '0,   0, 0, 1, 0, 0, 1,   0, 3, 0); // 34 disarm beats ack
        add(0, '0,   0, 1, 0, 0, 0, 0,   1, 3, 0); // 35 re-arm
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 3, 0); // 36..40 five bits, no match
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 3, 0);
        add(0, '0,   0, 0, 0, 0, 1, 1,   1, 3, 0);
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 3, 0);
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 3, 0);
        add(0, '0,   0, 0, 0, 0, 1, 1,   2, 3, 1); // 41 4th match saturates
        add(0, '0,   0, 0, 0, 0, 0, 1,   1, 3, 1); // 42 ack
        add(0, '0,   0, 0, 1, 0, 0, 0,   0, 3, 1); // 43 disarm
        add(1, P1,   0, 0, 0, 0, 0, 0,   0, 0, 0); // 44 reload clears count/sat
        add(0, '0,   0, 1, 0, 0, 0, 0,   1, 0, 0); // 45 arm
        add(1, '1,   1, 0, 0, 0, 0, 1,   1, 0, 0); // 46 cfg ignored in ARMED
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 0, 0); // 47..52 stream 101010
        add(0, '0,   0, 0, 0, 0, 1, 1,   1, 0, 0);
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 0, 0);
        add(0, '0,   0, 0, 0, 0, 1, 1,   1, 0, 0);
        add(0, '0,   0, 0, 0, 1, 1, 1,   1, 0, 0);
        add(0, '0,   0, 0, 0, 0, 1, 1,   2, 1, 0);
        add(1, '0,   0, 0, 0, 0, 0, 0,   2, 1, 0); // 53 cfg ignored in HOLD

        #12;
        chk_all(-1, 2'd0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            cfg_valid   = vecs[i].cv;
            cfg_pattern = vecs[i].pat;
            cfg_overlap = vecs[i].ov;
            arm         = vecs[i].arm;
            disarm      = vecs[i].dis;
            x           = vecs[i].x;
            x_valid     = vecs[i].xv;
            match_ready = vecs[i].mr;
            @(posedge clk);
            #1;
            chk_all(i, vecs[i].st, vecs[i].cnt, vecs[i].sat);
        end

        // async reset while in HOLD takes effect without a clock edge
        @(negedge clk);
        cfg_valid = 1'b0; arm = 1'b0; disarm = 1'b0; x_valid = 1'b0; match_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_all(100, 2'd0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        // pattern/loaded were cleared, so arm alone must be ignored
        @(negedge clk);
        arm = 1'b1;
        @(posedge clk);
        #1;
        chk_all(101, 2'd0, '0, 1'b0);
        @(negedge clk);
        arm = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_sched.md
Name: seq_det_sched

Overview:
- Armable, reprogrammable serial bit-pattern detector controller for the serial-pattern-detection datapath.
- Loads a pattern over a config handshake, then accepts the serial stream under valid/ready.
- Counts matches and presents each match as a Moore-style event held until the consumer acknowledges it.
- Sits between the serial bit source and the downstream event/interrupt logic.

Parameters:
- PAT_W, 6, pattern length in bits (power-on pattern target 110110)
- CNT_W, 8, match counter width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- cfg_valid  input  1  config request
- cfg_ready  output  1  high only in IDLE
- cfg_pattern  input  PAT_W  pattern; MSB is the first bit received
- cfg_overlap  input  1  1 = overlapping matches allowed
- arm  input  1  start detection (IDLE only)
- disarm  input  1  stop detection (ARMED/HOLD)
- x  input  1  serial data bit
- x_valid  input  1  bit qualifier
- x_ready  output  1  high only in ARMED
- match_valid  output  1  high only in HOLD
- match_ready  input  1  event acknowledge
- match_count  output  CNT_W  saturating match count
- count_sat  output  1  sticky; set when a match occurs with count already all-ones
- state  output  2  debug: 0 IDLE, 1 ARMED, 2 HOLD

Behaviour:
- Reset (async, rst=0):
  - state=IDLE.
  - Pattern, overlap, loaded, history, fill, match_count and count_sat all cleared.
  - Outputs: cfg_ready=1, x_ready=0, match_valid=0.
- Outputs cfg_ready, x_ready and match_valid decode state only (Moore); no combinational input-to-output paths.
- IDLE:
  - cfg_valid=1: latch cfg_pattern and cfg_overlap, set loaded, clear match_count and count_sat.
  - arm=1 with (loaded or cfg_valid the same cycle): go to ARMED, clear history and fill.
    - A same-cycle cfg and arm arms with the new pattern.
  - arm with nothing loaded: ignored.
- ARMED:
  - disarm=1: go to IDLE; any same-cycle bit is dropped.
  - Else on x_valid: h' = {history[PAT_W-2:0], x}; fill' = min(fill+1, PAT_W).
  - Match when fill' == PAT_W and h' == pattern.
  - On match:
    - Go to HOLD.
    - match_count += 1, saturating at all-ones; if already all-ones, set count_sat.
    - If overlap=0: clear fill (history is retained but ignored until refilled).
    - If overlap=1: fill stays PAT_W.
  - Latency: bit accepted in cycle N causes match_valid=1 in cycle N+1.
- HOLD:
  - x_ready=0, so no bits are consumed.
  - match_ready=1: go to ARMED next cycle. Minimum HOLD duration is 1 cycle, so at most one match per 2 cycles.
  - disarm=1 (has priority over match_ready): go to IDLE; the event is dropped but the count is kept.
- Re-arm always restarts history and fill; match_count persists until the next cfg load.
- cfg_valid outside IDLE: ignored (cfg_ready=0); the requester holds the request.
- Reset asserted mid-operation: immediate return to reset values, including pattern and loaded.
- Width rules:
  - Counter wraps never; it saturates.
  - fill is ceil(log2(PAT_W+1)) bits.

Test Plan:
- Reset / unloaded arm:
  - Reset → state=0, cfg_ready=1, x_ready=0, match_valid=0, match_count=0.
  - arm with nothing loaded → state stays 0.
- Basic match:
  - Load 110110 with overlap=0, arm, stream 1,1,0,1,1,0 (x_valid continuous, match_ready=1).
  - → match_valid=1 exactly one cycle after the 6th bit; match_count=1; state returns to 1.
- Overlap vs non-overlap:
  - Stream 110110110 with overlap=1 → 2 matches, count=2.
  - Same stream with overlap=0 → 1 match, count=1.
- Backpressure:
  - match_ready=0 for 5 cycles after a match → match_valid held for 5 cycles, x_ready=0, offered bits not consumed.
  - match_ready=1 → ARMED; the next bit is accepted.
- Disarm corners:
  - disarm with x_valid in the same cycle in ARMED → no shift, state=0.
  - disarm in HOLD with match_ready=1 → state=0, count kept.
  - Re-arm → history cleared; 5 bits of pattern do not match.
- Saturation and reload:
  - CNT_W=2: 4 matches → match_count=3, count_sat=1.
  - cfg reload in IDLE → count=0, count_sat=0.
  - Async reset mid-HOLD → all outputs at reset values immediately.
